// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue
//   Instruction buffer between fetch and decode. Up to two fetched
//   instructions (each with PC and fetch-exception flag) are pushed per
//   cycle. One instruction is presented per cycle to decode over a
//   valid/ready handshake. A flush discards all contents.
//
// Ports
//   clk, resetn              clock; asynchronous active-low reset
//   flush                    pipeline redirect, drop everything
//   in_valid[1:0]            per-lane push request (lane 1 only with lane 0)
//   in_pc0/in_instr0/in_exc0 lane 0 (older) instruction
//   in_pc1/in_instr1/in_exc1 lane 1 (younger) instruction
//   in_ready                 room for two entries (registered count only)
//   out_valid/out_pc/out_instr/out_exc  head entry presented to decode
//   out_ready                decode consumes head this cycle
//   count                    current occupancy
module fetch_instr_queue #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [31:0]      in_pc0,
  input  logic [31:0]      in_instr0,
  input  logic             in_exc0,
  input  logic [31:0]      in_pc1,
  input  logic [31:0]      in_instr1,
  input  logic             in_exc1,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             out_exc,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic             exc_q   [DEPTH];
  logic             exc_d   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push_one;
  logic             push_two;
  logic [1:0]       npush;
  logic             pop;
  logic [PTR_W-1:0] tail_plus1;

  // in_ready looks only at the registered count, so a same-cycle pop never
  // opens a combinational path from out_ready to in_ready.
  assign in_ready  = (count_q <= CNT_W'(DEPTH - 2));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Lane 1 alone (in_valid=10) is illegal and pushes nothing.
  assign push_one   = in_ready & ~flush & in_valid[0];
  assign push_two   = push_one & in_valid[1];
  assign npush      = {push_two, push_one & ~push_two};
  assign pop        = out_valid & out_ready & ~flush;
  assign tail_plus1 = tail_q + PTR_W'(1);

  // Head entry is read straight from storage; zeroed while empty.
  assign out_pc    = out_valid ? pc_q[head_q]    : '0;
  assign out_instr = out_valid ? instr_q[head_q] : '0;
  assign out_exc   = out_valid ? exc_q[head_q]   : 1'b0;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // Redirect overrides any same-cycle push or pop.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_one) begin
        pc_d[tail_q]    = in_pc0;
        instr_d[tail_q] = in_instr0;
        exc_d[tail_q]   = in_exc0;
      end
      if (push_two) begin
        pc_d[tail_plus1]    = in_pc1;
        instr_d[tail_plus1] = in_instr1;
        exc_d[tail_plus1]   = in_exc1;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      tail_d  = tail_q + PTR_W'(npush);
      head_d  = head_q + PTR_W'(pop);
      count_d = count_q + CNT_W'(npush) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        exc_q[i]   <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
    end
  end

  lane1_without_lane0 : assert property (@(posedge clk) disable iff (!resetn)
    in_valid != 2'b10);

  count_in_range : assert property (@(posedge clk) disable iff (!resetn)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_instr_queue.sv
// tb_fetch_instr_queue
//   Directed bench for fetch_instr_queue (DEPTH=8): reset/idle, dual push
//   and pop, fill to full with dropped push, pop-only at full, wrap-around
//   streaming with random consumer stalls, flush, and asynchronous reset.
module tb_fetch_instr_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             resetn;
  logic             flush;
  logic [1:0]       in_valid;
  logic [31:0]      in_pc0;
  logic [31:0]      in_instr0;
  logic             in_exc0;
  logic [31:0]      in_pc1;
  logic [31:0]      in_instr1;
  logic             in_exc1;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_exc;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  fetch_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc0    (in_pc0),
    .in_instr0 (in_instr0),
    .in_exc0   (in_exc0),
    .in_pc1    (in_pc1),
    .in_instr1 (in_instr1),
    .in_exc1   (in_exc1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_exc   (out_exc),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction words are derived from the PC so data can be checked too.
  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] pc0,
                               input logic [31:0] pc1, input logic exc0,
                               input logic exc1, input logic rdy, input logic fl);
    in_valid  = valid;
    in_pc0    = pc0;
    in_instr0 = instrOf(pc0);
    in_exc0   = exc0;
    in_pc1    = pc1;
    in_instr1 = instrOf(pc1);
    in_exc1   = exc1;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] expQ[$];
  logic [31:0] pcA;
  logic [1:0]  wv;
  logic        wr;
  int          pushed;
  int          consumed;
  int          cyc;

  initial begin
    resetn = 1'b0;
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset and idle
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
      checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
      checkOutput("idle_count", 32'(count), 32'd0);
    end

    // Dual push then two pops
    applyStimulus(2'b11, 32'hBFC0_0000, 32'hBFC0_0004, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("dual_count", 32'(count), 32'd2);
    checkOutput("dual_out_valid", 32'(out_valid), 32'd1);
    checkOutput("dual_out_pc", out_pc, 32'hBFC0_0000);
    checkOutput("dual_out_instr", out_instr, instrOf(32'hBFC0_0000));
    checkOutput("dual_out_exc", 32'(out_exc), 32'd0);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("pop1_out_pc", out_pc, 32'hBFC0_0004);
    checkOutput("pop1_out_exc", 32'(out_exc), 32'd1);
    checkOutput("pop1_count", 32'(count), 32'd1);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pop2_count", 32'(count), 32'd0);
    checkOutput("pop2_out_valid", 32'(out_valid), 32'd0);
    checkOutput("pop2_out_pc", out_pc, 32'd0);

    // Fill to DEPTH with four dual pushes, then a dropped fifth
    for (int i = 0; i < 4; i++) begin
      pcA = 32'h1000 + 32'(8 * i);
      applyStimulus(2'b11, pcA, pcA + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("fill_count", 32'(count), 32'(2 * (i + 1)));
      checkOutput("fill_in_ready", 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    applyStimulus(2'b11, 32'h3000, 32'h3004, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("full_drop_count", 32'(count), 32'd8);
    checkOutput("full_out_pc", out_pc, 32'h1000);

    // Push 01 with pop at full: only the pop happens
    applyStimulus(2'b01, 32'h3100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("fullpop_count", 32'(count), 32'd7);
    checkOutput("fullpop_out_pc", out_pc, 32'h1004);
    checkOutput("fullpop_in_ready", 32'(in_ready), 32'd0);
    for (int k = 1; k < 8; k++) begin
      checkOutput("drain_out_pc", out_pc, 32'h1000 + 32'(4 * k));
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_count", 32'(count), 32'd0);

    // Wrap-around stream of 20 PCs with random consumer stalls
    pushed   = 0;
    consumed = 0;
    cyc      = 0;
    while ((pushed < 20 || expQ.size() != 0) && cyc < 300) begin
      wr = (pushed >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      wv = 2'b00;
      if (pushed < 20 && (DEPTH - expQ.size()) >= 2)
        wv = ((20 - pushed) >= 2 && $urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
      pcA = 32'h100 + 32'(4 * pushed);
      applyStimulus(wv, pcA, pcA + 32'd4, 1'b0, 1'b0, wr, 1'b0);
      checkOutput("wrap_count", 32'(count), 32'(expQ.size()));
      checkOutput("wrap_out_valid", 32'(out_valid), (expQ.size() != 0) ? 32'd1 : 32'd0);
      if (expQ.size() != 0 && wr) begin
        checkOutput("wrap_out_pc", out_pc, expQ.pop_front());
        consumed++;
      end
      if (wv[0]) begin
        expQ.push_back(pcA);
        pushed++;
      end
      if (wv[1]) begin
        expQ.push_back(pcA + 32'd4);
        pushed++;
      end
      tick();
      cyc++;
    end
    checkOutput("wrap_timeout", (cyc < 300) ? 32'd1 : 32'd0, 32'd1);
    checkOutput("wrap_consumed", 32'(consumed), 32'd20);

    // Flush at count=5 with same-cycle push and pop
    applyStimulus(2'b11, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(2'b11, 32'h2008, 32'h200C, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(2'b01, 32'h2010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("preflush_count", 32'(count), 32'd5);
    applyStimulus(2'b11, 32'h2100, 32'h2104, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(2'b01, 32'h8000_0180, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("postflush_out_pc", out_pc, 32'h8000_0180);
    checkOutput("postflush_count", 32'(count), 32'd1);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("postflush_pop_count", 32'(count), 32'd0);

    // Flush while empty
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("emptyflush_count", 32'(count), 32'd0);
    checkOutput("emptyflush_out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream with count=4
    applyStimulus(2'b11, 32'h4000, 32'h4004, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(2'b11, 32'h4008, 32'h400C, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("prereset_count", 32'(count), 32'd4);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
    #1;
    resetn = 1'b1;
    tick();
    checkOutput("after_rst_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
